// File: rtl/intersection_scheduler.sv
// ----------------------------------------------------------------------------
// intersection_scheduler
//
// Purpose:
//   Two-approach (NS / EW) intersection controller. Sequences green, yellow
//   and all-red clearance for each approach, inserts pedestrian walk phases,
//   stretches green under heavy own-density traffic, cuts green early for
//   pedestrians or heavy cross traffic, and pre-empts for ambulances.
//   All lamp outputs are Moore-decoded from the phase state and registered
//   alongside it, so they always reflect the current phase.
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous, active-high reset
//   ped_req      in   pedestrian button, single-cycle pulse is enough
//   amb_ns       in   ambulance approaching on NS (level)
//   amb_ew       in   ambulance approaching on EW (level)
//   density_ns   in   NS traffic density, 2'b11 = heavy
//   density_ew   in   EW traffic density, 2'b11 = heavy
//   ns_red/ns_yellow/ns_green   out  NS lamps
//   ew_red/ew_yellow/ew_green   out  EW lamps
//   ped_walk     out  walk signal, high only in the walk phase
//   ped_pending  out  latched pedestrian request
// ----------------------------------------------------------------------------
module intersection_scheduler #(
   parameter int unsigned T_CLEAR      = 2,
   parameter int unsigned T_MIN_GREEN  = 5,
   parameter int unsigned T_GREEN_BASE = 8,
   parameter int unsigned T_GREEN_EXT  = 15,
   parameter int unsigned T_YELLOW     = 3,
   parameter int unsigned T_WALK       = 6,
   parameter int unsigned T_AMB_HOLD   = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ped_req,
   input  logic       amb_ns,
   input  logic       amb_ew,
   input  logic [1:0] density_ns,
   input  logic [1:0] density_ew,
   output logic       ns_red,
   output logic       ns_yellow,
   output logic       ns_green,
   output logic       ew_red,
   output logic       ew_yellow,
   output logic       ew_green,
   output logic       ped_walk,
   output logic       ped_pending
);

   typedef enum logic [2:0] {
      StAllRed,
      StNsGreen,
      StNsYellow,
      StEwGreen,
      StEwYellow,
      StPedWalk,
      StAmbNs,
      StAmbEw
   } state_t;

   // Terminal counts: a phase of length T exits when cnt == T-1.
   localparam logic [7:0] C_CLEAR      = 8'(T_CLEAR - 1);
   localparam logic [7:0] C_MIN_GREEN  = 8'(T_MIN_GREEN - 1);
   localparam logic [7:0] C_GREEN_BASE = 8'(T_GREEN_BASE - 1);
   localparam logic [7:0] C_GREEN_EXT  = 8'(T_GREEN_EXT - 1);
   localparam logic [7:0] C_YELLOW     = 8'(T_YELLOW - 1);
   localparam logic [7:0] C_WALK       = 8'(T_WALK - 1);
   localparam logic [7:0] C_AMB_HOLD   = 8'(T_AMB_HOLD - 1);

   // Lamp vector order: {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk}
   localparam logic [6:0] L_ALL_RED = 7'b100_100_0;

   // next_dir encoding
   localparam logic DIR_NS = 1'b0;
   localparam logic DIR_EW = 1'b1;

   state_t     r_state;
   logic [7:0] r_cnt;
   logic       r_next_dir;
   logic       r_ped_pending;
   logic [6:0] r_lamps;

   state_t     w_state_d;
   logic [7:0] w_cnt_d;
   logic       w_next_dir_d;
   logic       w_ped_pending_d;
   logic [6:0] w_lamps_d;
   logic       w_ns_done;
   logic       w_ew_done;

   // Green termination for one approach, excluding ambulance handling.
   // Using >= on the green length also covers the case where own density
   // drops after cnt has already passed the shorter base length.
   function automatic logic green_done(input logic [7:0] cnt,
                                       input logic [1:0] own,
                                       input logic [1:0] other,
                                       input logic       ped);
      logic [7:0] tg_last;
      logic       early;
      tg_last = (own == 2'b11) ? C_GREEN_EXT : C_GREEN_BASE;
      early   = (cnt >= C_MIN_GREEN) &&
                (ped || ((other == 2'b11) && (own != 2'b11)));
      return early || (cnt >= tg_last);
   endfunction

   function automatic logic [6:0] decode(input state_t s);
      logic [6:0] l;
      case (s)
         StNsGreen, StAmbNs: l = 7'b001_100_0;
         StNsYellow:         l = 7'b010_100_0;
         StEwGreen, StAmbEw: l = 7'b100_001_0;
         StEwYellow:         l = 7'b100_010_0;
         StPedWalk:          l = 7'b100_100_1;
         default:            l = L_ALL_RED;
      endcase
      return l;
   endfunction

   assign w_ns_done = green_done(r_cnt, density_ns, density_ew, r_ped_pending);
   assign w_ew_done = green_done(r_cnt, density_ew, density_ns, r_ped_pending);

   // Next-state logic
   always_comb begin
      w_state_d    = r_state;
      w_next_dir_d = r_next_dir;

      case (r_state)
         StAllRed: begin
            if (r_cnt == C_CLEAR) begin
               if (amb_ns) begin
                  w_state_d = StAmbNs;
               end else if (amb_ew) begin
                  w_state_d = StAmbEw;
               end else if (r_ped_pending) begin
                  w_state_d = StPedWalk;
               end else begin
                  w_state_d    = (r_next_dir == DIR_EW) ? StEwGreen : StNsGreen;
                  w_next_dir_d = ~r_next_dir;
               end
            end
         end

         StNsGreen: begin
            if (amb_ns) begin
               w_state_d = StAmbNs;
            end else if (amb_ew || w_ns_done) begin
               w_state_d = StNsYellow;
            end
         end

         StEwGreen: begin
            if (amb_ew) begin
               w_state_d = StAmbEw;
            end else if (amb_ns || w_ew_done) begin
               w_state_d = StEwYellow;
            end
         end

         // Yellow always runs its full length, ambulance or not.
         StNsYellow, StEwYellow: begin
            if (r_cnt == C_YELLOW) begin
               w_state_d = StAllRed;
            end
         end

         StPedWalk: begin
            if (amb_ns || amb_ew || (r_cnt == C_WALK)) begin
               w_state_d = StAllRed;
            end
         end

         // Hold for the minimum time, then for as long as the request stays.
         StAmbNs: begin
            if (!amb_ns && (r_cnt >= C_AMB_HOLD)) begin
               w_state_d    = StNsYellow;
               w_next_dir_d = DIR_EW;
            end
         end

         StAmbEw: begin
            if (!amb_ew && (r_cnt >= C_AMB_HOLD)) begin
               w_state_d    = StEwYellow;
               w_next_dir_d = DIR_NS;
            end
         end

         default: begin
            w_state_d = StAllRed;
         end
      endcase
   end

   // Phase counter: clears on every phase change, saturates at 255.
   always_comb begin
      w_cnt_d = r_cnt;
      if (w_state_d != r_state) begin
         w_cnt_d = 8'd0;
      end else if (r_cnt != 8'hFF) begin
         w_cnt_d = r_cnt + 8'd1;
      end
   end

   // A new request wins over the clear that happens on walk entry.
   always_comb begin
      w_ped_pending_d = r_ped_pending;
      if (ped_req) begin
         w_ped_pending_d = 1'b1;
      end else if ((w_state_d == StPedWalk) && (r_state != StPedWalk)) begin
         w_ped_pending_d = 1'b0;
      end
   end

   // Lamps are registered from the next phase so they line up with r_state.
   assign w_lamps_d = decode(w_state_d);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= StAllRed;
         r_cnt         <= 8'd0;
         r_next_dir    <= DIR_NS;
         r_ped_pending <= 1'b0;
         r_lamps       <= L_ALL_RED;
      end else begin
         r_state       <= w_state_d;
         r_cnt         <= w_cnt_d;
         r_next_dir    <= w_next_dir_d;
         r_ped_pending <= w_ped_pending_d;
         r_lamps       <= w_lamps_d;
      end
   end

   assign ns_red      = r_lamps[6];
   assign ns_yellow   = r_lamps[5];
   assign ns_green    = r_lamps[4];
   assign ew_red      = r_lamps[3];
   assign ew_yellow   = r_lamps[2];
   assign ew_green    = r_lamps[1];
   assign ped_walk    = r_lamps[0];
   assign ped_pending = r_ped_pending;

endmodule

// File: tb/tb_intersection_scheduler.sv
// ----------------------------------------------------------------------------
// tb_intersection_scheduler
//
// Directed bench for intersection_scheduler. Each test resets the DUT, builds
// an expected per-cycle lamp sequence by hand, applies stimulus at fixed
// cycle indices and compares the observed lamp vector on every falling edge.
// Observed vector: {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, ped_walk, ped_pending}
// ----------------------------------------------------------------------------
module tb_intersection_scheduler;

   localparam logic [7:0] P_AR   = 8'b100_100_0_0;
   localparam logic [7:0] P_NSG  = 8'b001_100_0_0;
   localparam logic [7:0] P_NSY  = 8'b010_100_0_0;
   localparam logic [7:0] P_EWG  = 8'b100_001_0_0;
   localparam logic [7:0] P_EWY  = 8'b100_010_0_0;
   localparam logic [7:0] P_WALK = 8'b100_100_1_0;
   localparam logic [7:0] PEND   = 8'b000_000_0_1;

   logic       clk;
   logic       reset;
   logic       ped_req;
   logic       amb_ns;
   logic       amb_ew;
   logic [1:0] density_ns;
   logic [1:0] density_ew;
   logic       ns_red, ns_yellow, ns_green;
   logic       ew_red, ew_yellow, ew_green;
   logic       ped_walk, ped_pending;
   logic [7:0] w_obs;

   int         checks;
   int         errors;
   logic [7:0] exp_q[$];

   intersection_scheduler dut (
      .clk        (clk),
      .reset      (reset),
      .ped_req    (ped_req),
      .amb_ns     (amb_ns),
      .amb_ew     (amb_ew),
      .density_ns (density_ns),
      .density_ew (density_ew),
      .ns_red     (ns_red),
      .ns_yellow  (ns_yellow),
      .ns_green   (ns_green),
      .ew_red     (ew_red),
      .ew_yellow  (ew_yellow),
      .ew_green   (ew_green),
      .ped_walk   (ped_walk),
      .ped_pending(ped_pending)
   );

   assign w_obs = {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green,
                   ped_walk, ped_pending};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic add(input logic [7:0] v, input int n);
      for (int k = 0; k < n; k++) exp_q.push_back(v);
   endtask

   // Hold reset for one cycle, release at a falling edge. On return the DUT
   // is in ALL_RED with cnt = 0 (index 0 of every sequence).
   task automatic do_reset(input logic [1:0] dns, input logic [1:0] dew);
      reset      = 1'b1;
      ped_req    = 1'b0;
      amb_ns     = 1'b0;
      amb_ew     = 1'b0;
      density_ns = dns;
      density_ew = dew;
      exp_q.delete();
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset   = 1'b1;
      ped_req = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (w_obs !== P_AR) begin
         errors++;
         $display("FAIL reset_state got=%b exp=%b", w_obs, P_AR);
      end
      ped_req = 1'b0;
   endtask

   task automatic test_cycle();
      do_reset(2'd0, 2'd0);
      add(P_AR, 2); add(P_NSG, 8); add(P_NSY, 3); add(P_AR, 2);
      add(P_EWG, 8); add(P_EWY, 3); add(P_AR, 2); add(P_NSG, 1);
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (w_obs !== exp_q[i]) begin
            errors++;
            $display("FAIL cycle idx=%0d got=%b exp=%b", i, w_obs, exp_q[i]);
         end
         checks++;
         if ((ns_red + ns_yellow + ns_green) != 1 ||
             (ew_red + ew_yellow + ew_green) != 1 || !(ns_red || ew_red)) begin
            errors++;
            $display("FAIL lamp_excl idx=%0d got=%b exp=one-hot-per-approach", i, w_obs);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_density();
      do_reset(2'd3, 2'd0);
      add(P_AR, 2); add(P_NSG, 15); add(P_NSY, 3); add(P_AR, 2);
      add(P_EWG, 15); add(P_EWY, 3); add(P_AR, 2); add(P_NSG, 5); add(P_NSY, 1);
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (w_obs !== exp_q[i]) begin
            errors++;
            $display("FAIL density idx=%0d got=%b exp=%b", i, w_obs, exp_q[i]);
         end
         if (i == 22) begin
            density_ns = 2'd0;
            density_ew = 2'd3;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_density_drop();
      do_reset(2'd3, 2'd0);
      add(P_AR, 2); add(P_NSG, 11); add(P_NSY, 3); add(P_AR, 2); add(P_EWG, 1);
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (w_obs !== exp_q[i]) begin
            errors++;
            $display("FAIL density_drop idx=%0d got=%b exp=%b", i, w_obs, exp_q[i]);
         end
         if (i == 12) density_ns = 2'd0;
         @(negedge clk);
      end
   endtask

   task automatic test_ped();
      do_reset(2'd0, 2'd0);
      add(P_AR, 2); add(P_NSG, 2); add(P_NSG | PEND, 3); add(P_NSY | PEND, 3);
      add(P_AR | PEND, 2); add(P_WALK, 6); add(P_AR, 2); add(P_EWG, 1);
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (w_obs !== exp_q[i]) begin
            errors++;
            $display("FAIL ped idx=%0d got=%b exp=%b", i, w_obs, exp_q[i]);
         end
         ped_req = (i == 3);
         @(negedge clk);
      end
   endtask

   task automatic test_amb_ew();
      do_reset(2'd0, 2'd0);
      add(P_AR, 2); add(P_NSG, 2); add(P_NSY, 3); add(P_AR, 2);
      add(P_EWG, 15); add(P_EWY, 3); add(P_AR, 2); add(P_NSG, 1);
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (w_obs !== exp_q[i]) begin
            errors++;
            $display("FAIL amb_ew idx=%0d got=%b exp=%b", i, w_obs, exp_q[i]);
         end
         if (i == 3)  amb_ew = 1'b1;
         if (i == 23) amb_ew = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic test_amb_ns();
      do_reset(2'd0, 2'd0);
      add(P_AR, 2); add(P_NSG, 12); add(P_NSY, 3); add(P_AR, 2); add(P_NSG, 3);
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (w_obs !== exp_q[i]) begin
            errors++;
            $display("FAIL amb_ns idx=%0d got=%b exp=%b", i, w_obs, exp_q[i]);
         end
         if (i == 3)  amb_ns = 1'b1;
         if (i == 5)  amb_ns = 1'b0;
         if (i == 17) begin
            amb_ns = 1'b1;
            amb_ew = 1'b1;
         end
         @(negedge clk);
      end
      amb_ns = 1'b0;
      amb_ew = 1'b0;
   endtask

   task automatic test_amb_walk();
      do_reset(2'd0, 2'd0);
      add(P_AR, 2); add(P_NSG, 2); add(P_NSG | PEND, 3); add(P_NSY | PEND, 3);
      add(P_AR | PEND, 2); add(P_WALK, 2); add(P_AR, 2); add(P_EWG, 2);
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (w_obs !== exp_q[i]) begin
            errors++;
            $display("FAIL amb_walk idx=%0d got=%b exp=%b", i, w_obs, exp_q[i]);
         end
         ped_req = (i == 3);
         if (i == 13) amb_ew = 1'b1;
         @(negedge clk);
      end
      amb_ew = 1'b0;
   endtask

   task automatic test_reset_mid_walk();
      do_reset(2'd0, 2'd0);
      add(P_AR, 2); add(P_NSG, 2); add(P_NSG | PEND, 3); add(P_NSY | PEND, 3);
      add(P_AR | PEND, 2); add(P_WALK, 2); add(P_WALK | PEND, 1);
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (w_obs !== exp_q[i]) begin
            errors++;
            $display("FAIL rst_walk idx=%0d got=%b exp=%b", i, w_obs, exp_q[i]);
         end
         ped_req = (i == 3) || (i == 13);
         @(negedge clk);
      end
      // Asynchronous reset away from any clock edge.
      reset = 1'b1;
      #1;
      checks++;
      if (w_obs !== P_AR) begin
         errors++;
         $display("FAIL rst_async got=%b exp=%b", w_obs, P_AR);
      end
      @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
      add(P_AR, 2); add(P_NSG, 1);
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (w_obs !== exp_q[i]) begin
            errors++;
            $display("FAIL rst_restart idx=%0d got=%b exp=%b", i, w_obs, exp_q[i]);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      reset      = 1'b1;
      ped_req    = 1'b0;
      amb_ns     = 1'b0;
      amb_ew     = 1'b0;
      density_ns = 2'd0;
      density_ew = 2'd0;
      test_reset();
      test_cycle();
      test_density();
      test_density_drop();
      test_ped();
      test_amb_ew();
      test_amb_ns();
      test_amb_walk();
      test_reset_mid_walk();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
